// File: rtl/follow_seq.sv
// follow_seq: run-control sequencer ahead of the line-follow PID.
// Arms on a stable line, drives go, and decimates raw errors into error/err_vld.
module follow_seq #(
  parameter bit FAST_SIM = 1'b0,
  parameter int DECIM    = 4,
  parameter int ARM_CYC  = 50000,
  parameter int LOST_TO  = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        line_present,
  input  logic [15:0] raw_err,
  input  logic        raw_vld,
  output logic        go,
  output logic [15:0] error,
  output logic        err_vld,
  output logic        lost,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, FOLLOW = 3'd2, LOST = 3'd3, STOP = 3'd4} state_t;
  localparam int ARM_R  = FAST_SIM ? ARM_CYC / 16 : ARM_CYC;
  localparam int LOST_R = FAST_SIM ? LOST_TO / 16 : LOST_TO;
  localparam int ARM_T  = ARM_R > 0 ? ARM_R : 1;
  localparam int LOST_T = LOST_R > 0 ? LOST_R : 1;
  localparam int CW     = $clog2((ARM_T > LOST_T ? ARM_T : LOST_T) + 1);
  localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_T - 1);
  localparam logic [CW-1:0] LOST_LAST = CW'(LOST_T - 1);
  localparam logic [3:0]    DEC_LAST  = 4'(DECIM - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d, lost_cnt_q, lost_cnt_d;
  logic [3:0]    decim_cnt_q, decim_cnt_d;
  logic [15:0]   last_err_q, last_err_d, error_q, error_d;
  logic          go_q, go_d, err_vld_q, err_vld_d, lost_q, lost_d;
  logic          dec_hit;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction
  assign dec_hit = decim_cnt_q == DEC_LAST;
  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    decim_cnt_d = decim_cnt_q;
    last_err_d  = last_err_q;
    error_d     = error_q;
    lost_d      = lost_q;
    err_vld_d   = 1'b0;
    case (state_q)
      IDLE, STOP: if (cmd_start) begin
        state_d   = ARM;
        arm_cnt_d = '0;
        lost_d    = 1'b0;
      end
      ARM: if (!line_present) arm_cnt_d = '0;
        else if (arm_cnt_q == ARM_LAST) begin
          state_d     = FOLLOW;
          decim_cnt_d = 4'd0;
        end else arm_cnt_d = sat_inc(arm_cnt_q);
      FOLLOW: if (!line_present) begin
        state_d    = LOST;
        lost_cnt_d = '0;
      end
      LOST: if (line_present) state_d = FOLLOW;
        else if (lost_cnt_q == LOST_LAST) begin
          state_d = STOP;
          lost_d  = 1'b1;
        end else lost_cnt_d = sat_inc(lost_cnt_q);
      default: state_d = IDLE;
    endcase
    // stop overrides every transition, including the lost set/clear it would cause
    if (cmd_stop) begin
      state_d = IDLE;
      lost_d  = lost_q;
    end
    go_d = state_d == FOLLOW || state_d == LOST;
    if (go_q && raw_vld) begin
      decim_cnt_d = dec_hit ? 4'd0 : decim_cnt_q + 4'd1;
      if (dec_hit && state_q == FOLLOW) last_err_d = raw_err;
      if (dec_hit && go_d) begin
        error_d   = state_q == FOLLOW ? raw_err : last_err_q;
        err_vld_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arm_cnt_q   <= '0;
      lost_cnt_q  <= '0;
      decim_cnt_q <= 4'd0;
      last_err_q  <= 16'd0;
      error_q     <= 16'd0;
      go_q        <= 1'b0;
      err_vld_q   <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      decim_cnt_q <= decim_cnt_d;
      last_err_q  <= last_err_d;
      error_q     <= error_d;
      go_q        <= go_d;
      err_vld_q   <= err_vld_d;
      lost_q      <= lost_d;
    end
  end
  assign go      = go_q;
  assign error   = error_q;
  assign err_vld = err_vld_q;
  assign lost    = lost_q;
  assign state   = state_q;
endmodule

// File: tb/tb_follow_seq.sv
// tb_follow_seq: vector table for arming plus scripted dropout, timeout, abort and reset sequences.
// Decimated outputs are checked against a queue of expected {value, cycle} records.
module tb_follow_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, line_present = 1'b0, raw_vld = 1'b0;
  logic [15:0] raw_err = 16'd0;
  logic        go, err_vld, lost;
  logic [15:0] error;
  logic [2:0]  state;
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {logic [15:0] val; int due;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  typedef struct {logic s, p, l, v; logic [15:0] e; logic [2:0] st; logic go; logic lost;} vec_t;
  vec_t tbl[13];

  follow_seq #(.FAST_SIM(1'b1), .DECIM(4), .ARM_CYC(160), .LOST_TO(320)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .line_present(line_present), .raw_err(raw_err), .raw_vld(raw_vld),
    .go(go), .error(error), .err_vld(err_vld), .lost(lost), .state(state));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic l, input logic v, input logic [15:0] e);
    cmd_start = s; cmd_stop = p; line_present = l; raw_vld = v; raw_err = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    q.push_back('{v, cyc + 1});
  endtask

  task automatic arm_run(input string tag);
    drive(1, 0, 1, 0, 0);
    tick();
    chk({tag, "_arm_state"}, state, 1);
    chk({tag, "_arm_lost"}, lost, 0);
    for (int j = 1; j <= 10; j++) begin
      drive(0, 0, 1, 0, 0);
      tick();
      if (j == 9) chk({tag, "_go_early"}, go, 0);
    end
    chk({tag, "_follow_state"}, state, 2);
    chk({tag, "_follow_go"}, go, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && err_vld) begin
      chk("err_vld_with_go", go, 1);
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_err_vld: got err_vld=1 error=%0h, expected no strobe (cycle %0d)", error, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("error_value", error, mon_e.val);
        chk("err_latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    tbl[0] = '{0, 0, 1, 0, 16'h0000, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1, 0, 1, 0, 16'h0000, 3'd1, 1'b0, 1'b0};
    for (int i = 2; i <= 10; i++) tbl[i] = '{0, 0, 1, 1, 16'h1234, 3'd1, 1'b0, 1'b0};
    tbl[11] = '{0, 0, 1, 1, 16'h1234, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{1, 0, 1, 0, 16'h0000, 3'd2, 1'b1, 1'b0};
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_go", go, 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_error", error, 0);
    chk("rst_lost", lost, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].l, tbl[i].v, tbl[i].e);
      tick();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_go", i), go, tbl[i].go);
      chk($sformatf("tbl%0d_lost", i), lost, tbl[i].lost);
    end
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 1, 16'(k));
      if (k % 4 == 0) push(16'(k));
      tick();
      repeat (4) begin
        drive(0, 0, 1, 0, 0);
        tick();
      end
    end
    chk("decim_hold_error", error, 16'h0008);
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, (i >= 1 && i <= 4), 16'h7777);
      if (i == 4) push(16'h0008);
      tick();
      if (i == 0 || i == 14) begin
        chk("drop_state", state, 3);
        chk("drop_go", go, 1);
      end
    end
    drive(0, 0, 1, 0, 0);
    tick();
    chk("recover_state", state, 2);
    chk("recover_lost", lost, 0);
    chk("recover_error", error, 16'h0008);
    for (int i = 0; i <= 20; i++) begin
      drive(0, 0, 0, i >= 17, 16'h5555);
      tick();
      if (i == 19) begin
        chk("timeout_pre_state", state, 3);
        chk("timeout_pre_go", go, 1);
      end
    end
    chk("timeout_state", state, 4);
    chk("timeout_go", go, 0);
    chk("timeout_lost", lost, 1);
    chk("timeout_err_vld", err_vld, 0);
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("stop_hold_state", state, 4);
    chk("stop_hold_lost", lost, 1);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("restart_state", state, 1);
    chk("restart_lost", lost, 0);
    for (int j = 1; j <= 8; j++) begin
      drive(0, 0, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    chk("glitch_state", state, 1);
    for (int j = 1; j <= 9; j++) begin
      drive(0, 0, 1, 0, 0);
      tick();
      if (j == 1 || j == 9) begin
        chk("glitch_arm_state", state, 1);
        chk("glitch_arm_go", go, 0);
      end
    end
    drive(0, 0, 1, 0, 0);
    tick();
    chk("glitch_follow_state", state, 2);
    chk("glitch_follow_go", go, 1);
    repeat (2) begin
      drive(0, 0, 1, 1, 16'h0021);
      tick();
      drive(0, 0, 1, 0, 0);
      tick();
    end
    for (int i = 0; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
    chk("stop2_state", state, 4);
    chk("stop2_lost", lost, 1);
    drive(1, 1, 0, 0, 0);
    tick();
    chk("start_stop_state", state, 0);
    chk("start_stop_lost", lost, 1);
    chk("start_stop_go", go, 0);
    arm_run("rearm");
    for (int k = 11; k <= 14; k++) begin
      drive(0, 0, 1, 1, 16'(k));
      if (k == 14) push(16'(k));
      tick();
      drive(0, 0, 1, 0, 0);
      tick();
    end
    drive(0, 1, 1, 0, 0);
    tick();
    chk("abort_state", state, 0);
    chk("abort_go", go, 0);
    arm_run("rearm2");
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, 16'h0031 + 16'(k));
      if (k == 3) push(16'h0034);
      tick();
    end
    drive(0, 0, 1, 0, 0);
    chk("pre_reset_err_vld", err_vld, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_go", go, 0);
    chk("async_err_vld", err_vld, 0);
    chk("async_error", error, 0);
    chk("async_state", state, 0);
    chk("async_lost", lost, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", state, 0);
    chk("post_reset_go", go, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
